delay_line_ctrl: RTL and testbench

Sequencer for the single-port 1024×17 delay memory used by the echo/delay effect. On every audio sample strobe it reads the tap `DELAY_LEN` samples back, writes the new sample plus scaled feedback at the write pointer, and emits the mixed output. It sits between the voice/mixer sample stream and the delay memory instance, and owns every memory port signal. After reset and on request it zero-fills the whole memory.

---
 rtl/delay_line_ctrl.sv | 131 +++++++++++++
 tb/tb_delay_line_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/delay_line_ctrl.sv
// Sequencer for the 1024x17 echo/delay memory: zero-fills the memory after reset
// and on request. For each sample it reads the delayed tap, writes back the input plus scaled feedback, and emits the mix.
module delay_line_ctrl #(
    parameter int DEPTH_LOG2 = 10,
    parameter int DW         = 17
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DW-1:0]         sample_in,
    input  logic                  sample_valid,
    input  logic [DEPTH_LOG2-1:0] delay_len,
    input  logic [7:0]            feedback,
    input  logic                  clear_req,
    output logic [DEPTH_LOG2-1:0] mem_addr,
    output logic [DW-1:0]         mem_di,
    output logic                  mem_we,
    input  logic [DW-1:0]         mem_do,
    output logic [DW-1:0]         sample_out,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  overrun
);

    typedef enum logic [2:0] {CLEAR, IDLE, READ, CAPT, WRITE, OUT} state_t;

    state_t                state;
    logic [DEPTH_LOG2-1:0] clr_cnt;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DW-1:0]         in_r;
    logic [DEPTH_LOG2-1:0] len_r;
    logic [7:0]            fb_r;
    logic [DW-1:0]         tap;

    logic [DW-1:0]         tap_next;
    logic [DW+8:0]         tap_ext;
    logic [DW+8:0]         fb_ext;
    logic [DW:0]           scaled;
    logic [DW:0]           wr_sum;
    logic [DW:0]           out_sum;

    // Clamp an 18-bit sum back into the signed 17-bit sample range.
    function automatic logic [DW-1:0] sat(input logic [DW:0] x);
        if (x[DW] != x[DW-1])
            return x[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        return x[DW-1:0];
    endfunction

    // The write-back word needs the tap in the same edge that captures it, so it is taken straight from mem_do.
    assign tap_next = (len_r == '0) ? '0 : mem_do;
    assign tap_ext  = {{9{tap_next[DW-1]}}, tap_next};
    assign fb_ext   = {{(DW+1){1'b0}}, fb_r};
    assign scaled   = (DW+1)'((tap_ext * fb_ext) >> 8);
    assign wr_sum   = {in_r[DW-1], in_r} + scaled;
    assign out_sum  = {in_r[DW-1], in_r} + {tap[DW-1], tap};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CLEAR;
            clr_cnt    <= '0;
            wr_ptr     <= '0;
            in_r       <= '0;
            len_r      <= '0;
            fb_r       <= '0;
            tap        <= '0;
            mem_addr   <= '0;
            mem_di     <= '0;
            mem_we     <= 1'b0;
            sample_out <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b1;
            overrun    <= 1'b0;
        end else begin
            mem_we    <= 1'b0;
            out_valid <= 1'b0;
            if (sample_valid && state != IDLE)
                overrun <= 1'b1;

            case (state)
                CLEAR: begin
                    mem_we   <= 1'b1;
                    mem_addr <= clr_cnt;
                    mem_di   <= '0;
                    wr_ptr   <= '0;
                    clr_cnt  <= clr_cnt + DEPTH_LOG2'(1);
                    if (clr_cnt == '1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                IDLE: begin
                    if (sample_valid) begin
                        in_r     <= sample_in;
                        len_r    <= delay_len;
                        fb_r     <= feedback;
                        mem_addr <= wr_ptr - delay_len;
                        state    <= READ;
                        busy     <= 1'b1;
                    end else if (clear_req) begin
                        clr_cnt <= '0;
                        state   <= CLEAR;
                        busy    <= 1'b1;
                    end
                end
                READ: begin
                    state <= CAPT;
                end
                CAPT: begin
                    tap      <= tap_next;
                    mem_addr <= wr_ptr;
                    mem_di   <= sat(wr_sum);
                    mem_we   <= 1'b1;
                    state    <= WRITE;
                end
                WRITE: begin
                    sample_out <= sat(out_sum);
                    out_valid  <= 1'b1;
                    state      <= OUT;
                end
                OUT: begin
                    wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
                    state  <= IDLE;
                    busy   <= 1'b0;
                end
                default: begin
                    state <= CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Scoreboard bench for delay_line_ctrl: a behavioural delay-line model predicts each
// output and its due cycle; a monitor pops and compares whenever out_valid fires.
module tb_delay_line_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [16:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic [9:0]  delay_len = '0;
    logic [7:0]  feedback = '0;
    logic        clear_req = 1'b0;
    logic [9:0]  mem_addr;
    logic [16:0] mem_di;
    logic        mem_we;
    logic [16:0] mem_do = '0;
    logic [16:0] sample_out;
    logic        out_valid;
    logic        busy;
    logic        overrun;

    logic [16:0] mem [0:1023];

    int ref_mem [1024];
    int ref_wp;
    int exp_val [$];
    int exp_due [$];
    int compared = 0;
    int mismatched = 0;
    int cycle_count = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cycle_count <= cycle_count + 1;

    delay_line_ctrl #(.DEPTH_LOG2(10), .DW(17)) dut (
        .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
        .delay_len(delay_len), .feedback(feedback), .clear_req(clear_req),
        .mem_addr(mem_addr), .mem_di(mem_di), .mem_we(mem_we), .mem_do(mem_do),
        .sample_out(sample_out), .out_valid(out_valid), .busy(busy), .overrun(overrun)
    );

    // Single-port synchronous RAM: read data appears one cycle after the address.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_di;
        mem_do <= mem[mem_addr];
    end

    task automatic check_output(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int sat17(input int x);
        if (x > 65535) return 65535;
        if (x < -65536) return -65536;
        return x;
    endfunction

    task automatic model_reset();
        foreach (ref_mem[i]) ref_mem[i] = 0;
        ref_wp = 0;
    endtask

    // Reference delay line: integer arithmetic on a plain array, floor-shifted feedback.
    task automatic model_accept(input int val, input int len, input int fb);
        int tap;
        int fed;
        tap = (len == 0) ? 0 : ref_mem[(ref_wp - len + 1024) % 1024];
        fed = (tap * fb) >>> 8;
        ref_mem[ref_wp] = sat17(val + fed);
        exp_val.push_back(sat17(val + tap));
        exp_due.push_back(cycle_count + 4);
        ref_wp = (ref_wp + 1) % 1024;
    endtask

    // Called #1 after a rising edge in an IDLE cycle; leaves the bench `gap` cycles later.
    task automatic apply_stimulus(input int val, input int len, input int fb, input int gap);
        sample_in    = 17'(val);
        delay_len    = 10'(len);
        feedback     = 8'(fb);
        sample_valid = 1'b1;
        model_accept(val, len, fb);
        @(posedge clk); #1;
        sample_valid = 1'b0;
        clear_req    = 1'b0;
        sample_in    = 17'($urandom);
        delay_len    = 10'($urandom);
        feedback     = 8'($urandom);
        repeat (gap - 1) begin
            @(posedge clk); #1;
        end
    endtask

    // Called in the first CLEAR cycle; walks the 1024-cycle zero-fill.
    task automatic check_clear(input string name);
        int bad;
        bad = busy ? 0 : 1;
        for (int k = 1; k <= 1024; k++) begin
            @(posedge clk); #1;
            if (!mem_we || mem_addr != 10'(k - 1) || mem_di != 17'd0) bad++;
            if (k < 1024 && !busy) bad++;
        end
        check_output(name, bad, 0);
        check_output({name, "_busy_done"}, int'(busy), 0);
    endtask

    task automatic request_clear();
        clear_req = 1'b1;
        @(posedge clk); #1;
        clear_req = 1'b0;
        model_reset();
        check_clear("req_clear");
    endtask

    always @(negedge clk) begin : monitor
        int v;
        int d;
        if (rst_n && out_valid) begin
            if (exp_val.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_out: got %0d, expected no output", $signed(sample_out));
            end else begin
                v = exp_val.pop_front();
                d = exp_due.pop_front();
                check_output("out_value", int'($signed(sample_out)), v);
                check_output("out_latency", cycle_count, d);
            end
        end
    end

    initial begin
        int len;
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_busy", int'(busy), 1);
        check_output("rst_mem_we", int'(mem_we), 0);
        check_output("rst_mem_addr", int'(mem_addr), 0);
        check_output("rst_out_valid", int'(out_valid), 0);
        check_output("rst_overrun", int'(overrun), 0);
        rst_n = 1'b1;
        model_reset();
        check_clear("reset_clear");
        check_output("idle_sample_out", int'(sample_out), 0);

        $display("[TB] delay 3, no feedback");
        for (int i = 1; i <= 5; i++) apply_stimulus(100 * i, 3, 0, 8);

        $display("[TB] feedback impulse");
        request_clear();
        apply_stimulus(1024, 1, 8'h80, 6);
        for (int i = 0; i < 6; i++) apply_stimulus(0, 1, 8'h80, 6);

        $display("[TB] saturation");
        request_clear();
        apply_stimulus(60000, 1, 0, 6);
        apply_stimulus(60000, 1, 0, 6);
        apply_stimulus(-60000, 1, 0, 6);
        apply_stimulus(-60000, 1, 0, 6);

        $display("[TB] wrap with delay 1023");
        request_clear();
        for (int n = 0; n < 1030; n++) apply_stimulus(n, 1023, 0, 5);

        $display("[TB] bypass");
        for (int i = 0; i < 20; i++)
            apply_stimulus(int'($urandom_range(0, 131071)) - 65536, 0, int'($urandom_range(0, 255)), 5);

        $display("[TB] priority of sample over clear");
        clear_req = 1'b1;
        apply_stimulus(1234, 1, 64, 6);
        check_output("no_clear_busy", int'(busy), 0);
        check_output("no_overrun_yet", int'(overrun), 0);
        apply_stimulus(0, 1, 64, 6);

        $display("[TB] overrun");
        apply_stimulus(555, 2, 32, 2);
        sample_in    = 17'd999;
        sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check_output("overrun_set", int'(overrun), 1);
        apply_stimulus(1, 1, 0, 6);
        check_output("overrun_sticky", int'(overrun), 1);

        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++) begin
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 1023));
            apply_stimulus(int'($urandom_range(0, 131071)) - 65536, len,
                           int'($urandom_range(0, 255)), int'($urandom_range(5, 8)));
        end

        $display("[TB] reset mid-sample");
        apply_stimulus(42, 1, 0, 2);
        rst_n = 1'b0;
        exp_val.delete();
        exp_due.delete();
        @(posedge clk); #1;
        check_output("rst2_busy", int'(busy), 1);
        check_output("rst2_overrun", int'(overrun), 0);
        rst_n = 1'b1;
        model_reset();
        check_clear("reset2_clear");
        apply_stimulus(321, 1, 0, 6);
        apply_stimulus(7, 1, 255, 6);

        repeat (10) @(posedge clk);
        #1;
        check_output("pending_outputs", exp_val.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
